// File: rtl/bsg_mul_iterative_issue_pkg.sv
// Shared types for the RV32M iterative multiplier issue block: opcode and FSM enums,
// request queue entry layout, and signedness decode helpers.
package bsg_mul_iterative_issue_pkg;

   // Entry fields are sized here; keep these equal to the top's width_p / tag_width_p.
   localparam int width_gp     = 32;
   localparam int tag_width_gp = 5;

   typedef enum logic [1:0] {
      eMUL    = 2'd0,
      eMULH   = 2'd1,
      eMULHSU = 2'd2,
      eMULHU  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      eIDLE = 2'd0,
      eWAIT = 2'd1,
      eOUT  = 2'd2
   } state_e;

   typedef struct packed {
      op_e                     op;
      logic [width_gp-1:0]     opA;
      logic [width_gp-1:0]     opB;
      logic [tag_width_gp-1:0] tag;
   } entry_s;

   function automatic logic op_a_is_signed(input op_e op);
      return (op == eMULH) || (op == eMULHSU);
   endfunction

   function automatic logic op_b_is_signed(input op_e op);
      return (op == eMULH);
   endfunction

endpackage

// File: rtl/bsg_mul_iterative_issue_queue.sv
// els_p-entry request FIFO (v/ready in, v/yumi out); head is registered, no bypass when full.
module bsg_mul_iterative_issue_queue
   import bsg_mul_iterative_issue_pkg::*;
#(
   parameter int els_p = 2
) (
   input  logic   clk_i,
   input  logic   reset_n_i,
   input  logic   v_i,
   input  entry_s data_i,
   output logic   ready_o,
   output logic   v_o,
   output entry_s data_o,
   input  logic   yumi_i
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

   entry_s                mem_r [els_p];
   logic [ptr_w_lp-1:0]   wptr_r, rptr_r;
   logic [ptr_w_lp:0]     count_r;
   logic                  enq, deq;

   assign ready_o = (count_r != (ptr_w_lp+1)'(els_p));
   assign v_o     = (count_r != '0);
   assign data_o  = mem_r[rptr_r];
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;

   // NOTE: storage is not reset; count_r alone decides which entries are valid.
   always_ff @(posedge clk_i) begin
      if (enq) mem_r[wptr_r] <= data_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (enq) wptr_r <= wptr_r + 1'b1;
         if (deq) rptr_r <= rptr_r + 1'b1;
         case ({enq, deq})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/bsg_mul_iterative_issue.sv
// RV32M MUL/MULH/MULHSU/MULHU issue and result-select front end for an iterative multiplier.
// Optional: BSG_MUL_ITERATIVE_ISSUE_ZERO_BYPASS_EN retires zero-operand requests without the multiplier.
module bsg_mul_iterative_issue
   import bsg_mul_iterative_issue_pkg::*;
#(
   parameter int width_p     = width_gp,
   parameter int tag_width_p = tag_width_gp,
   parameter int els_p       = 2
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   v_i,
   output logic                   ready_o,
   input  logic [1:0]             op_i,
   input  logic [width_p-1:0]     opA_i,
   input  logic [width_p-1:0]     opB_i,
   input  logic [tag_width_p-1:0] tag_i,
   output logic                   v_o,
   output logic [width_p-1:0]     result_o,
   output logic [tag_width_p-1:0] tag_o,
   input  logic                   yumi_i,
   output logic                   mul_v_o,
   input  logic                   mul_ready_i,
   output logic [width_p-1:0]     mul_opA_o,
   output logic [width_p-1:0]     mul_opB_o,
   output logic                   mul_opA_is_signed_o,
   output logic                   mul_opB_is_signed_o,
   input  logic                   mul_v_i,
   input  logic [2*width_p-1:0]   mul_result_i,
   output logic                   mul_yumi_o
);

   entry_s enq_entry, head;
   logic   head_v, head_yumi;

   assign enq_entry = '{op: op_e'(op_i), opA: opA_i, opB: opB_i, tag: tag_i};

   bsg_mul_iterative_issue_queue #(.els_p(els_p)) queue (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (v_i),
      .data_i    (enq_entry),
      .ready_o   (ready_o),
      .v_o       (head_v),
      .data_o    (head),
      .yumi_i    (head_yumi)
   );

   assign mul_opA_o           = head.opA;
   assign mul_opB_o           = head.opB;
   assign mul_opA_is_signed_o = op_a_is_signed(head.op);
   assign mul_opB_is_signed_o = op_b_is_signed(head.op);

   state_e                 state_r, state_n;
   op_e                    inflight_op_r;
   logic [tag_width_p-1:0] inflight_tag_r, tag_r, tag_n;
   logic [width_p-1:0]     result_r, result_n;
   logic                   load_inflight, load_result;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_n       = state_r;
      mul_v_o       = 1'b0;
      mul_yumi_o    = 1'b0;
      head_yumi     = 1'b0;
      v_o           = 1'b0;
      load_inflight = 1'b0;
      load_result   = 1'b0;
      result_n      = '0;
      tag_n         = '0;
      case (state_r)
         eIDLE: begin
`ifdef BSG_MUL_ITERATIVE_ISSUE_ZERO_BYPASS_EN
            if (head_v && (head.opA == '0 || head.opB == '0)) begin
               head_yumi   = 1'b1;
               load_result = 1'b1;
               tag_n       = head.tag;
               state_n     = eOUT;
            end else
`endif
            begin
               mul_v_o = head_v;
               if (head_v && mul_ready_i) begin
                  head_yumi     = 1'b1;
                  load_inflight = 1'b1;
                  state_n       = eWAIT;
               end
            end
         end
         eWAIT: begin
            mul_yumi_o = mul_v_i;
            if (mul_v_i) begin
               load_result = 1'b1;
               result_n    = (inflight_op_r == eMUL) ? mul_result_i[width_p-1:0]
                                                     : mul_result_i[2*width_p-1:width_p];
               tag_n       = inflight_tag_r;
               state_n     = eOUT;
            end
         end
         eOUT: begin
            v_o = 1'b1;
            if (yumi_i) state_n = eIDLE;
         end
         default: state_n = eIDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r        <= eIDLE;
         inflight_op_r  <= eMUL;
         inflight_tag_r <= '0;
         result_r       <= '0;
         tag_r          <= '0;
      end else begin
         state_r <= state_n;
         if (load_inflight) begin
            inflight_op_r  <= head.op;
            inflight_tag_r <= head.tag;
         end
         if (load_result) begin
            result_r <= result_n;
            tag_r    <= tag_n;
         end
      end
   end

   assign result_o = result_r;
   assign tag_o    = tag_r;

endmodule
